// File: rtl/qpsk_pkg.sv
// Shared QPSK constants and sample helpers used by the modulator and the demodulator.
// Samples are {HDR, c, c} with c the 2-bit signed constellation point.
package qpsk_pkg;

   localparam logic [3:0]        HDR       = 4'b0111;
   localparam logic signed [1:0] CONST_POS = 2'sb01;
   localparam logic signed [1:0] CONST_NEG = 2'sb11;

   // Hard decision: +1 (01) -> 1, -1 (11) -> 0.
   function automatic logic slice(input logic [7:0] sample);
      return ~sample[1];
   endfunction

   function automatic logic sample_ok(input logic [7:0] sample, input logic [3:0] hdr = HDR);
      return (sample[7:4] == hdr) && (sample[3:2] == sample[1:0]) &&
             ((sample[1:0] == CONST_POS) || (sample[1:0] == CONST_NEG));
   endfunction

endpackage

// File: rtl/qpsk_slicer.sv
// Combinational I/Q hard slicer: yields the Q (older) and I (newer) bits plus a malformed flag.
// Zero latency, no flow control.
module qpsk_slicer
   import qpsk_pkg::*;
#(
   parameter logic [3:0] HDR = qpsk_pkg::HDR
)(
   input  logic [7:0] i_iz,
   input  logic [7:0] i_qz,
   output logic       o_qbit,
   output logic       o_ibit,
   output logic       o_bad
);

   assign o_qbit = slice(i_qz);
   assign o_ibit = slice(i_iz);
   assign o_bad  = ~sample_ok(i_iz, HDR) | ~sample_ok(i_qz, HDR);

endmodule

// File: rtl/qpsk_demod.sv
// QPSK demodulator: slices I/Q symbols and packs them LSB-first into words; 1 clock from the last symbol.
// No backpressure on the symbol side; a word completing while the output is still held is dropped (overrun).
module qpsk_demod
   import qpsk_pkg::*;
#(
   parameter int         BYTE_BITS = 8,
   parameter logic [3:0] HDR       = qpsk_pkg::HDR,
   parameter int         ERR_W     = 8,
   localparam int        SPW       = BYTE_BITS / 2,
   localparam int        CNT_W     = (SPW > 1) ? $clog2(SPW) : 1
)(
   input  logic                 CLOCK_50,
   input  logic                 iRST_N,
   input  logic [7:0]           Iz_signal,
   input  logic [7:0]           Qz_signal,
   input  logic                 sym_valid,
   input  logic                 resync,
   input  logic                 clr_status,
   output logic [BYTE_BITS-1:0] byte_out,
   output logic                 byte_valid,
   input  logic                 byte_ready,
   output logic                 overrun,
   output logic [ERR_W-1:0]     err_count,
   output logic [CNT_W-1:0]     sym_cnt
);

   logic [BYTE_BITS-1:0] r_acc;
   logic [BYTE_BITS-1:0] r_byte;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_vld;
   logic                 r_ovr;
   logic [ERR_W-1:0]     r_err;

   logic [BYTE_BITS-1:0] w_word;
   logic                 w_qbit;
   logic                 w_ibit;
   logic                 w_bad;
   logic                 w_sym;
   logic                 w_last;
   logic                 w_free;
   logic                 w_take;

   qpsk_slicer #(.HDR(HDR)) u_slicer (
      .i_iz   (Iz_signal),
      .i_qz   (Qz_signal),
      .o_qbit (w_qbit),
      .o_ibit (w_ibit),
      .o_bad  (w_bad)
   );

   // Partial word with the current symbol merged into slot r_cnt.
   always_comb begin
      w_word = r_acc;
      for (int k = 0; k < SPW; k++) begin
         if (CNT_W'(k) == r_cnt) begin
            w_word[2*k]   = w_qbit;
            w_word[2*k+1] = w_ibit;
         end
      end
   end

   assign w_sym  = sym_valid & ~resync;
   assign w_last = w_sym & (r_cnt == CNT_W'(SPW - 1));
   assign w_free = ~r_vld | byte_ready;
   assign w_take = w_last & w_free;

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (resync) begin
         r_cnt <= '0;
      end else if (sym_valid) begin
         r_acc <= w_word;
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         r_byte <= '0;
         r_vld  <= 1'b0;
      end else if (w_take) begin
         r_byte <= w_word;
         r_vld  <= 1'b1;
      end else if (r_vld && byte_ready) begin
         r_vld  <= 1'b0;
      end
   end

   // Clear has priority over any event arriving in the same cycle.
   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         r_ovr <= 1'b0;
         r_err <= '0;
      end else if (clr_status) begin
         r_ovr <= 1'b0;
         r_err <= '0;
      end else begin
         if (w_last && !w_free) begin
            r_ovr <= 1'b1;
         end
         if (w_sym && w_bad && (r_err != '1)) begin
            r_err <= r_err + 1'b1;
         end
      end
   end

   assign byte_out   = r_byte;
   assign byte_valid = r_vld;
   assign overrun    = r_ovr;
   assign err_count  = r_err;
   assign sym_cnt    = r_cnt;

endmodule

// File: tb/tb_qpsk_demod.sv
// Randomized and directed bench for qpsk_demod against a queue-based word model.
module tb_qpsk_demod;

   localparam int SPW = 4;

   logic       CLOCK_50;
   logic       iRST_N;
   logic [7:0] Iz_signal;
   logic [7:0] Qz_signal;
   logic       sym_valid;
   logic       resync;
   logic       clr_status;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       overrun;
   logic [7:0] err_count;
   logic [1:0] sym_cnt;

   qpsk_demod dut (
      .CLOCK_50   (CLOCK_50),
      .iRST_N     (iRST_N),
      .Iz_signal  (Iz_signal),
      .Qz_signal  (Qz_signal),
      .sym_valid  (sym_valid),
      .resync     (resync),
      .clr_status (clr_status),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .overrun    (overrun),
      .err_count  (err_count),
      .sym_cnt    (sym_cnt)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference state: pending symbol bits, held word, status.
   int         q_bits[$];
   int         i_bits[$];
   logic [7:0] m_byte;
   bit         m_vld;
   bit         m_ovr;
   int         m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_bit(input logic [7:0] s);
      int v;
      v = int'(s);
      return (((v / 2) % 2) == 0) ? 1 : 0;
   endfunction

   function automatic bit ref_ok(input logic [7:0] s);
      int v;
      v = int'(s);
      return ((v / 16) == 7) && (((v / 4) % 4) == (v % 4)) && ((v % 2) == 1);
   endfunction

   function automatic logic [7:0] good(input int b);
      return (b != 0) ? 8'h75 : 8'h7F;
   endfunction

   task automatic model_reset();
      q_bits.delete();
      i_bits.delete();
      m_byte = 8'h00;
      m_vld  = 1'b0;
      m_ovr  = 1'b0;
      m_err  = 0;
   endtask

   task automatic model_step(input bit sv, input bit rs, input bit cl, input bit rd,
                             input logic [7:0] iz, input logic [7:0] qz);
      bit consumed;
      bit loaded;
      bit ovr_ev;
      bit bad_ev;
      int word;
      consumed = m_vld && rd;
      loaded   = 1'b0;
      ovr_ev   = 1'b0;
      bad_ev   = 1'b0;
      if (rs) begin
         q_bits.delete();
         i_bits.delete();
      end else if (sv) begin
         q_bits.push_back(ref_bit(qz));
         i_bits.push_back(ref_bit(iz));
         bad_ev = !ref_ok(iz) || !ref_ok(qz);
         if (q_bits.size() == SPW) begin
            word = 0;
            for (int k = 0; k < SPW; k++)
               word = word + (q_bits[k] << (2 * k)) + (i_bits[k] << (2 * k + 1));
            q_bits.delete();
            i_bits.delete();
            if (!m_vld || rd) begin
               m_byte = 8'(word);
               loaded = 1'b1;
            end else begin
               ovr_ev = 1'b1;
            end
         end
      end
      if (loaded) m_vld = 1'b1;
      else if (consumed) m_vld = 1'b0;
      if (cl) begin
         m_ovr = 1'b0;
         m_err = 0;
      end else begin
         if (ovr_ev) m_ovr = 1'b1;
         if (bad_ev && m_err < 255) m_err++;
      end
   endtask

   // Called at a falling edge; drives one cycle, checks after the rising edge, returns at the next falling edge.
   task automatic tick(input bit sv, input bit rs, input bit cl, input bit rd,
                       input logic [7:0] iz, input logic [7:0] qz);
      sym_valid  = sv;
      resync     = rs;
      clr_status = cl;
      byte_ready = rd;
      Iz_signal  = iz;
      Qz_signal  = qz;
      model_step(sv, rs, cl, rd, iz, qz);
      @(posedge CLOCK_50);
      #1;
      chk("byte_valid", byte_valid, m_vld);
      chk("byte_out", byte_out, m_byte);
      chk("overrun", overrun, m_ovr);
      chk("err_count", err_count, m_err);
      chk("sym_cnt", sym_cnt, q_bits.size());
      @(negedge CLOCK_50);
   endtask

   task automatic send_sym(input int k, input logic [7:0] w, input bit rd);
      logic [7:0] wv;
      wv = w;
      tick(1'b1, 1'b0, 1'b0, rd, good(wv[2*k+1]), good(wv[2*k]));
   endtask

   task automatic send_word(input logic [7:0] w, input bit rd_early, input bit rd_last);
      for (int k = 0; k < SPW; k++)
         send_sym(k, w, (k == SPW - 1) ? rd_last : rd_early);
   endtask

   task automatic idle(input bit rd);
      tick(1'b0, 1'b0, 1'b0, rd, 8'h00, 8'h00);
   endtask

   initial begin
      iRST_N     = 1'b0;
      sym_valid  = 1'b0;
      resync     = 1'b0;
      clr_status = 1'b0;
      byte_ready = 1'b0;
      Iz_signal  = 8'h00;
      Qz_signal  = 8'h00;
      model_reset();
      repeat (2) @(negedge CLOCK_50);
      chk("rst_valid", byte_valid, 0);
      chk("rst_byte", byte_out, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_err", err_count, 0);
      chk("rst_cnt", sym_cnt, 0);
      iRST_N = 1'b1;
      @(negedge CLOCK_50);

      // Loopback word 0x5F.
      send_word(8'h5F, 1'b1, 1'b1);
      chk("loop_byte", byte_out, 32'h5F);
      chk("loop_vld", byte_valid, 1);
      chk("loop_err", err_count, 0);
      idle(1'b1);
      chk("loop_drain", byte_valid, 0);

      // Backpressure and overrun.
      send_word(8'h5F, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0);
      chk("bp_hold", byte_out, 32'h5F);
      chk("bp_ovr", overrun, 1);
      idle(1'b1);
      chk("bp_drain", byte_valid, 0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      chk("ovr_clr", overrun, 0);

      // Consume and complete in the same cycle.
      send_word(8'h12, 1'b0, 1'b0);
      send_word(8'hC9, 1'b0, 1'b1);
      chk("sim_vld", byte_valid, 1);
      chk("sim_byte", byte_out, 32'hC9);
      chk("sim_ovr", overrun, 0);
      idle(1'b1);

      // Malformed samples and saturation.
      tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h74, 8'h65);
      chk("bad_one", err_count, 1);
      for (int n = 0; n < 299; n++) tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h74, 8'h65);
      chk("bad_sat", err_count, 32'hFF);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      chk("bad_clr", err_count, 0);

      // Resync discards a partial word.
      tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
      send_sym(0, 8'hFF, 1'b1);
      send_sym(1, 8'hFF, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
      send_word(8'hA6, 1'b1, 1'b1);
      chk("rs_byte", byte_out, 32'hA6);
      tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h75, 8'h75);
      chk("rs_drop", sym_cnt, 0);

      // Reset mid-word with a held byte.
      send_word(8'h77, 1'b0, 1'b0);
      send_sym(0, 8'h00, 1'b0);
      send_sym(1, 8'h00, 1'b0);
      #2 iRST_N = 1'b0;
      #1;
      chk("amid_valid", byte_valid, 0);
      chk("amid_byte", byte_out, 0);
      chk("amid_ovr", overrun, 0);
      chk("amid_err", err_count, 0);
      chk("amid_cnt", sym_cnt, 0);
      model_reset();
      @(negedge CLOCK_50);
      iRST_N = 1'b1;
      send_word(8'hE4, 1'b1, 1'b1);
      chk("post_rst_byte", byte_out, 32'hE4);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] iz;
         logic [7:0] qz;
         iz = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : good($urandom_range(0, 1));
         qz = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : good($urandom_range(0, 1));
         tick($urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2,
              $urandom_range(0, 1) == 1, iz, qz);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qpsk_demod.md
Name: qpsk_demod

Overview:
- Receive-side counterpart of the QPSK modulator: accepts 8-bit I/Q constellation samples in the modulator's output format, hard-slices each sample pair back to 2 bits and reassembles them into bytes.
- Bytes are presented on a valid/ready output port.
- Also flags malformed samples and output overruns for debug on the board.
- Sits between the sample source (modulator loopback, or the channel model) and the byte sink.

Parameters:
- BYTE_BITS, 8: bits per output word; must be even. Symbols per word = BYTE_BITS/2.
- HDR, 4'b0111: expected upper nibble of every valid sample.
- ERR_W, 8: width of the saturating bad-symbol counter.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- Iz_signal  in  8  I sample, format {HDR, c, c}, where c is the 2-bit signed constellation point.
- Qz_signal  in  8  Q sample, same format.
- sym_valid  in  1  Iz/Qz carry a new symbol this cycle. There is no backpressure on the symbol side.
- resync  in  1  synchronous; discard the partial word and restart word alignment.
- clr_status  in  1  synchronous; clear overrun and err_count.
- byte_out  out  BYTE_BITS  assembled word.
- byte_valid  out  1  byte_out holds an unconsumed word.
- byte_ready  in  1  sink accepts the word when byte_valid && byte_ready.
- overrun  out  1  sticky: a completed word was dropped.
- err_count  out  ERR_W  saturating count of malformed samples.
- sym_cnt  out  log2(BYTE_BITS/2)  symbols in the current partial word.

Behaviour:
- Slicing (combinational on the inputs): bit = ~sample[1].
  - c=01 (+1) gives bit 1; c=11 (-1) gives bit 0.
  - Example: 0x75 -> 1, 0x7F -> 0.
- Symbol bit order: the Q bit is the older bit and the I bit the newer, matching the modulator's parallel_out[1]/[0] pairing.
- Word assembly: LSB-first. Symbol k (k = 0..BYTE_BITS/2-1) writes Q bit to word[2k] and I bit to word[2k+1].
- Malformed sample: applies per channel, checked only when sym_valid is high. A sample is malformed if any of the following holds:
  - sample[7:4] != HDR
  - sample[3:2] != sample[1:0]
  - sample[0] == 0 (codes 00 and 10 are illegal)
- Malformed handling:
  - The sample is still hard-sliced and used in the word.
  - err_count increments by 1 per malformed symbol (I and/or Q bad counts once).
  - err_count saturates at all-ones.
- FSM, two states:
  - ACC: shift register collecting symbols; sym_cnt counts 0..BYTE_BITS/2-1.
  - FULL_WAIT: not a separate state. Output is a one-entry holding register flagged by byte_valid.
- Completion: when sym_valid arrives with sym_cnt == BYTE_BITS/2-1:
  - sym_cnt wraps to 0.
  - If the holding register is free (byte_valid == 0, or a handshake occurs in this same cycle), byte_out and byte_valid load on that edge. Latency is 1 clock from the final symbol's sampling edge.
  - Otherwise the new word is dropped, overrun sets, and the held byte_out is unchanged.
- Handshake:
  - byte_valid is held until byte_valid && byte_ready.
  - byte_out is stable while byte_valid is high.
  - Simultaneous consume and new completion: the new word loads and byte_valid stays 1.
- resync:
  - sym_cnt goes to 0 and the partial word is discarded.
  - The holding register and status are unaffected.
  - resync together with sym_valid: resync wins and the symbol is discarded.
- clr_status together with a new malformed symbol or new overrun: the clear wins that cycle.
- Reset (async assert, sync-safe release) sets byte_out=0, byte_valid=0, overrun=0, err_count=0, sym_cnt=0.
  - Reset mid-word drops the partial word.

Decomposition:
- Package qpsk_pkg holds:
  - constants HDR, CONST_POS=2'sb01, CONST_NEG=2'sb11;
  - function slice(sample) returning the bit;
  - function sample_ok(sample).
- The modulator and this block both use the package.
- One sub-module: qpsk_slicer, a combinational I/Q to {qbit, ibit, bad}. Everything else stays in qpsk_demod.

Test Plan:
- Loopback: feed the I/Q stream for 8'b01011111 as 4 symbols (Q,I) = (1,1),(1,1),(1,0),(1,0) with Iz/Qz from {0x75, 0x7F}, byte_ready=1 -> byte_out=0x5F, byte_valid pulses 1 cycle after the 4th symbol, err_count=0.
- Backpressure: byte_ready=0, send 2 full words -> first word held stable, overrun=1 after the 8th symbol. Raise byte_ready -> the first word is consumed and byte_valid drops.
- Simultaneous consume and completion: the 4th symbol of word 2 arrives in the cycle byte_ready=1 -> word 2 loads, byte_valid stays 1, overrun=0.
- Malformed: send I=0x74, Q=0x65 in one symbol -> err_count += 1. Apply 300 bad symbols -> err_count=0xFF. clr_status -> 0.
- resync after 2 symbols, then 4 clean symbols -> only the last 4 form byte_out. resync together with sym_valid -> that symbol is ignored.
- Assert iRST_N low mid-word with byte_valid=1 -> all outputs 0 immediately. After release, a clean 4-symbol word is assembled correctly.
